antifurto_ctrl_multi: RTL and testbench

//  Parametrised anti-theft controller. Replaces the external-timer FSM with an

---
 rtl/antifurto_ctrl_multi.sv | 173 +++++++++++++++++
 tb/tb_antifurto_ctrl_multi.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/antifurto_ctrl_multi.sv
// Anti-theft controller: integrated 1 Hz countdown, N door channels,
// run-time programmable delays and a bounded alarm re-trigger count.
module antifurto_ctrl_multi #(
   parameter int N_DOORS   = 4,
   parameter int TW        = 4,
   parameter int T_ARM_DEF = 6,
   parameter int T_DRV_DEF = 8,
   parameter int T_PAS_DEF = 15,
   parameter int T_ALM_DEF = 10,
   parameter int MAX_ALM   = 3
) (
   input  logic               i_clock,
   input  logic               i_reset_n,
   input  logic               i_one_hz_enable,
   input  logic               i_ignition,
   input  logic [N_DOORS-1:0] i_door,
   input  logic               i_reprogram,
   input  logic [1:0]         i_prog_sel,
   input  logic [TW-1:0]      i_prog_val,
   output logic               o_status,
   output logic               o_siren,
   output logic [2:0]         o_estado,
   output logic [TW-1:0]      o_timer_value,
   output logic [1:0]         o_alarm_count
);

   typedef enum logic [2:0] {
      S_ARMED      = 3'd0,
      S_TRIGGERED  = 3'd1,
      S_ALARM      = 3'd2,
      S_DISARMED   = 3'd3,
      S_WAIT_OPEN  = 3'd4,
      S_WAIT_CLOSE = 3'd5,
      S_ARM_DLY    = 3'd6
   } state_t;

   localparam logic [1:0] L_MAX = 2'(MAX_ALM);

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] r_t_arm;
   logic [TW-1:0] r_t_drv;
   logic [TW-1:0] r_t_pas;
   logic [TW-1:0] r_t_alm;
   logic [1:0]    r_cnt;
   logic          r_status;
   logic          r_siren;

   logic          w_any;
   logic          w_exp;
   logic [TW-1:0] w_tdec;
   logic [1:0]    w_cnt_inc;

   assign w_any     = |i_door;
   assign w_exp     = (r_timer == '0);
   assign w_tdec    = (i_one_hz_enable && !w_exp) ? r_timer - TW'(1) : r_timer;
   assign w_cnt_inc = (r_cnt == L_MAX) ? r_cnt : r_cnt + 2'd1;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= S_ARMED;
         r_timer  <= '0;
         r_t_arm  <= TW'(T_ARM_DEF);
         r_t_drv  <= TW'(T_DRV_DEF);
         r_t_pas  <= TW'(T_PAS_DEF);
         r_t_alm  <= TW'(T_ALM_DEF);
         r_cnt    <= '0;
         r_status <= 1'b0;
         r_siren  <= 1'b0;
      end else begin
         if (r_state == S_DISARMED && i_reprogram) begin
            unique case (i_prog_sel)
               2'd0: r_t_arm <= i_prog_val;
               2'd1: r_t_drv <= i_prog_val;
               2'd2: r_t_pas <= i_prog_val;
               2'd3: r_t_alm <= i_prog_val;
            endcase
         end
         r_timer <= w_tdec;
         unique case (r_state)
            S_ARMED: begin
               r_timer <= '0;
               if (i_ignition) begin
                  r_state  <= S_DISARMED;
                  r_status <= 1'b0;
               end else if (w_any) begin
                  r_state  <= S_TRIGGERED;
                  r_timer  <= i_door[0] ? r_t_drv : r_t_pas;
                  r_status <= 1'b1;
               end else if (i_one_hz_enable) begin
                  r_status <= ~r_status;
               end
            end
            S_TRIGGERED: begin
               if (i_ignition) begin
                  r_state  <= S_DISARMED;
                  r_timer  <= '0;
                  r_cnt    <= '0;
                  r_status <= 1'b0;
               end else if (w_exp) begin
                  r_state <= S_ALARM;
                  r_timer <= r_t_alm;
                  r_cnt   <= w_cnt_inc;
                  r_siren <= 1'b1;
               end
            end
            S_ALARM: begin
               if (i_ignition) begin
                  r_state  <= S_DISARMED;
                  r_timer  <= '0;
                  r_cnt    <= '0;
                  r_status <= 1'b0;
                  r_siren  <= 1'b0;
               end else if (w_exp) begin
                  // re-trigger only while a door stays open and budget remains
                  if (w_any && r_cnt < L_MAX) begin
                     r_timer <= r_t_alm;
                     r_cnt   <= w_cnt_inc;
                  end else begin
                     r_state  <= S_ARMED;
                     r_timer  <= '0;
                     r_cnt    <= '0;
                     r_status <= 1'b0;
                     r_siren  <= 1'b0;
                  end
               end
            end
            S_DISARMED: begin
               r_timer <= '0;
               if (!i_ignition) r_state <= S_WAIT_OPEN;
            end
            S_WAIT_OPEN: begin
               r_timer <= '0;
               if (i_ignition) r_state <= S_DISARMED;
               else if (i_door[0]) r_state <= S_WAIT_CLOSE;
            end
            S_WAIT_CLOSE: begin
               r_timer <= '0;
               if (!i_door[0]) begin
                  r_state <= S_ARM_DLY;
                  r_timer <= r_t_arm;
               end
            end
            S_ARM_DLY: begin
               if (i_ignition) begin
                  r_state <= S_DISARMED;
                  r_timer <= '0;
               end else if (w_any) begin
                  r_timer <= r_t_arm;
               end else if (w_exp) begin
                  r_state  <= S_ARMED;
                  r_timer  <= '0;
                  r_status <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_ARMED;
               r_timer  <= '0;
               r_cnt    <= '0;
               r_status <= 1'b0;
               r_siren  <= 1'b0;
            end
         endcase
      end
   end

   assign o_status      = r_status;
   assign o_siren       = r_siren;
   assign o_estado      = r_state;
   assign o_timer_value = r_timer;
   assign o_alarm_count = r_cnt;

endmodule

// File: tb/tb_antifurto_ctrl_multi.sv
// Testbench for antifurto_ctrl_multi: directed scenarios plus a randomized
// run, all checked against a behavioural model of the state rules.
module tb_antifurto_ctrl_multi;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       ign = 1'b0;
   logic [3:0] door = 4'd0;
   logic       rp = 1'b0;
   logic [1:0] sel = 2'd0;
   logic [3:0] val = 4'd0;
   logic       status;
   logic       siren;
   logic [2:0] estado;
   logic [3:0] tval;
   logic [1:0] acnt;

   int checks = 0;
   int failures = 0;

   int m_state;
   int m_timer;
   int m_cnt;
   bit m_status;
   bit m_siren;
   int m_reg[4];

   always #5 clk = ~clk;

   antifurto_ctrl_multi dut (
      .i_clock(clk),
      .i_reset_n(rst_n),
      .i_one_hz_enable(tick),
      .i_ignition(ign),
      .i_door(door),
      .i_reprogram(rp),
      .i_prog_sel(sel),
      .i_prog_val(val),
      .o_status(status),
      .o_siren(siren),
      .o_estado(estado),
      .o_timer_value(tval),
      .o_alarm_count(acnt)
   );

   function automatic logic [10:0] dut_vec();
      return {estado, tval, acnt, status, siren};
   endfunction

   function automatic logic [10:0] mod_vec();
      return {3'(m_state), 4'(m_timer), 2'(m_cnt), m_status, m_siren};
   endfunction

   task automatic model_reset();
      m_state = 0; m_timer = 0; m_cnt = 0;
      m_status = 0; m_siren = 0;
      m_reg[0] = 6; m_reg[1] = 8; m_reg[2] = 15; m_reg[3] = 10;
   endtask

   // state codes: 0 armed 1 triggered 2 alarm 3 disarmed 4 wait_open
   // 5 wait_close 6 arm_dly
   task automatic model_step(input bit i, input logic [3:0] d, input bit t,
                             input bit p, input logic [1:0] s, input logic [3:0] v);
      int ns;
      int ld;
      int nc;
      bit any;
      bit ex;
      ns = m_state; ld = -1; nc = m_cnt;
      any = (d != 4'd0);
      ex = (m_timer == 0);
      case (m_state)
         0: if (i) ns = 3;
            else if (any) begin ns = 1; ld = d[0] ? m_reg[1] : m_reg[2]; end
         1: if (i) ns = 3;
            else if (ex) begin
               ns = 2; ld = m_reg[3]; nc = (m_cnt < 3) ? m_cnt + 1 : 3;
            end
         2: if (i) ns = 3;
            else if (ex) begin
               if (any && m_cnt < 3) begin ld = m_reg[3]; nc = m_cnt + 1; end
               else ns = 0;
            end
         3: if (!i) ns = 4;
         4: if (i) ns = 3; else if (d[0]) ns = 5;
         5: if (!d[0]) begin ns = 6; ld = m_reg[0]; end
         6: if (i) ns = 3; else if (any) ld = m_reg[0]; else if (ex) ns = 0;
         default: ns = 0;
      endcase
      if (m_state == 3 && p) m_reg[s] = int'(v);
      if (ld >= 0) m_timer = ld;
      else if (ns == 1 || ns == 2 || ns == 6) begin
         if (t && m_timer > 0) m_timer = m_timer - 1;
      end else m_timer = 0;
      if (ns == 0 || ns == 3) nc = 0;
      if (ns == 0) m_status = (m_state == 0) ? (m_status ^ t) : 1'b0;
      else m_status = (ns == 1 || ns == 2);
      m_siren = (ns == 2);
      m_cnt = nc;
      m_state = ns;
   endtask

   task automatic cyc(input bit i, input logic [3:0] d, input bit t,
                      input bit p, input logic [1:0] s, input logic [3:0] v);
      ign = i; door = d; tick = t; rp = p; sel = s; val = v;
      @(posedge clk);
      model_step(i, d, t, p, s, v);
      #1;
   endtask

   task automatic go(input bit i, input logic [3:0] d);
      cyc(i, d, 1'b1, 1'b0, 2'd0, 4'd0);
   endtask

   task automatic apply_reset();
      ign = 0; door = 0; tick = 0; rp = 0; sel = 0; val = 0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (dut_vec() !== 11'd0) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", dut_vec(), 11'd0);
      end
      go(0, 4'd0);
      checks++;
      if (dut_vec() !== mod_vec() || status !== 1'b1) begin
         failures++;
         $display("FAIL armed_blink: got %h expected %h", dut_vec(), mod_vec());
      end
   endtask

   task automatic test_pas_trigger();
      int n;
      apply_reset();
      go(0, 4'b0010);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd15}) begin
         failures++;
         $display("FAIL pas_load: got %0d/%0d expected 1/15", estado, tval);
      end
      n = 0;
      for (int k = 0; k < 40 && estado == 3'd1; k++) begin
         go(0, 4'd0);
         if (estado == 3'd1) n++;
      end
      checks++;
      if (n !== 15) begin
         failures++;
         $display("FAIL pas_countdown: got %0d expected 15", n);
      end
      checks++;
      if ({estado, siren, acnt, tval} !== {3'd2, 1'b1, 2'd1, 4'd10}
          || dut_vec() !== mod_vec()) begin
         failures++;
         $display("FAIL pas_alarm: got %h expected %h", dut_vec(), mod_vec());
      end
   endtask

   task automatic test_drv_trigger();
      apply_reset();
      go(0, 4'b0011);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd8} || dut_vec() !== mod_vec()) begin
         failures++;
         $display("FAIL drv_load: got %0d/%0d expected 1/8", estado, tval);
      end
   endtask

   task automatic test_alarm_retrigger();
      int n;
      int mx;
      int bad;
      apply_reset();
      go(0, 4'b0100);
      n = 0; mx = 0; bad = 0;
      for (int k = 0; k < 100 && estado != 3'd0; k++) begin
         go(0, 4'b0100);
         if (dut_vec() !== mod_vec()) bad++;
         if (estado == 3'd2) n++;
         if (int'(acnt) > mx) mx = int'(acnt);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL retrig_model: got %0d bad cycles expected 0", bad);
      end
      checks++;
      if (n !== 33 || mx !== 3) begin
         failures++;
         $display("FAIL retrig_cycles: got %0d/%0d expected 33/3", n, mx);
      end
      checks++;
      if ({estado, siren, acnt} !== {3'd0, 1'b0, 2'd0}) begin
         failures++;
         $display("FAIL retrig_end: got %0d/%0d/%0d expected 0/0/0", estado, siren, acnt);
      end
      go(0, 4'd0);
   endtask

   task automatic test_reprogram();
      int n;
      go(1, 4'd0);
      cyc(1, 4'd0, 1'b1, 1'b1, 2'd1, 4'd2);
      go(0, 4'd0);
      cyc(0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd1);
      checks++;
      if (estado !== 3'd4 || dut_vec() !== mod_vec()) begin
         failures++;
         $display("FAIL prog_wait_open: got %h expected %h", dut_vec(), mod_vec());
      end
      go(0, 4'b0001);
      go(0, 4'd0);
      checks++;
      if ({estado, tval} !== {3'd6, 4'd6}) begin
         failures++;
         $display("FAIL prog_armdly: got %0d/%0d expected 6/6", estado, tval);
      end
      n = 0;
      for (int k = 0; k < 20 && estado == 3'd6; k++) begin
         go(0, 4'd0);
         if (estado == 3'd6) n++;
      end
      checks++;
      if (n !== 6 || estado !== 3'd0) begin
         failures++;
         $display("FAIL prog_arming: got %0d/%0d expected 6/0", n, estado);
      end
      go(0, 4'b0001);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd2}) begin
         failures++;
         $display("FAIL prog_drv_load: got %0d/%0d expected 1/2", estado, tval);
      end
      n = 0;
      for (int k = 0; k < 20 && estado == 3'd1; k++) begin
         go(0, 4'd0);
         if (estado == 3'd1) n++;
      end
      checks++;
      if (n !== 2 || estado !== 3'd2 || dut_vec() !== mod_vec()) begin
         failures++;
         $display("FAIL prog_drv_alarm: got %0d/%0d expected 2/2", n, estado);
      end
   endtask

   task automatic test_armdly_reload();
      apply_reset();
      go(1, 4'd0);
      go(0, 4'd0);
      go(0, 4'b0001);
      go(0, 4'd0);
      for (int k = 0; k < 10 && tval != 4'd3; k++) go(0, 4'd0);
      checks++;
      if ({estado, tval} !== {3'd6, 4'd3}) begin
         failures++;
         $display("FAIL armdly_at3: got %0d/%0d expected 6/3", estado, tval);
      end
      go(0, 4'b0010);
      checks++;
      if ({estado, tval} !== {3'd6, 4'd6}) begin
         failures++;
         $display("FAIL armdly_reload: got %0d/%0d expected 6/6", estado, tval);
      end
      for (int k = 0; k < 20 && estado == 3'd6; k++) go(0, 4'd0);
      go(0, 4'b0010);
      for (int k = 0; k < 30 && estado == 3'd1 && tval != 4'd0; k++) go(0, 4'd0);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd0}) begin
         failures++;
         $display("FAIL trig_expiry: got %0d/%0d expected 1/0", estado, tval);
      end
      go(1, 4'd0);
      checks++;
      if (estado !== 3'd3 || siren !== 1'b0 || dut_vec() !== mod_vec()) begin
         failures++;
         $display("FAIL ign_priority: got %0d expected 3", estado);
      end
   endtask

   task automatic test_async_reset();
      cyc(1, 4'd0, 1'b1, 1'b1, 2'd1, 4'd3);
      go(0, 4'd0);
      go(0, 4'b0001);
      go(0, 4'd0);
      for (int k = 0; k < 20 && estado == 3'd6; k++) go(0, 4'd0);
      go(0, 4'b0001);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd3}) begin
         failures++;
         $display("FAIL rst_prog_drv: got %0d/%0d expected 1/3", estado, tval);
      end
      for (int k = 0; k < 20 && estado == 3'd1; k++) go(0, 4'd0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({estado, siren} !== {3'd0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset: got %0d/%0d expected 0/0", estado, siren);
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      go(0, 4'b0001);
      checks++;
      if ({estado, tval} !== {3'd1, 4'd8}) begin
         failures++;
         $display("FAIL rst_defaults: got %0d/%0d expected 1/8", estado, tval);
      end
   endtask

   task automatic test_random();
      int bad;
      logic [3:0] d;
      apply_reset();
      bad = 0;
      for (int k = 0; k < 4000; k++) begin
         d = ($urandom % 6 == 0) ? 4'($urandom) : 4'd0;
         cyc(($urandom % 10) == 0, d, ($urandom % 3) == 0,
             ($urandom % 8) == 0, 2'($urandom), 4'($urandom));
         checks++;
         if (dut_vec() !== mod_vec()) begin
            failures++;
            bad++;
            if (bad < 10)
               $display("FAIL random_cycle %0d: got %h expected %h", k, dut_vec(), mod_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pas_trigger();
      test_drv_trigger();
      test_alarm_retrigger();
      test_reprogram();
      test_armdly_reload();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
